// File: rtl/ahb_fir_sample_master_pkg.sv
// rtl/ahb_fir_sample_master_pkg.sv - shared types and constants for the FIR AHB-Lite master
package fir_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SMP_A  = 4'd1,
    ST_SMP_D  = 4'd2,
    ST_POLL_A = 4'd3,
    ST_POLL_D = 4'd4,
    ST_RES_A  = 4'd5,
    ST_RES_D  = 4'd6,
    ST_OUT    = 4'd7,
    ST_CF_A   = 4'd8,
    ST_CF_D   = 4'd9
  } state_t;

  typedef enum logic {
    OP_SAMPLE = 1'b0,
    OP_COEFF  = 1'b1
  } op_t;

  localparam logic [3:0] ADDR_STATUS  = 4'h0;
  localparam logic [3:0] ADDR_RESULT  = 4'h2;
  localparam logic [3:0] ADDR_SAMPLE  = 4'h4;
  localparam logic [3:0] ADDR_F0      = 4'h6;
  localparam logic [3:0] ADDR_NEWCOEF = 4'hE;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 8;

  // Index 4 is the NEW_COEFF_SET strobe that follows F0..F3.
  localparam logic [2:0] CF_LAST_IDX = 3'd4;

  // F0..F3 at 0x6..0xC, and index 4 lands on NEW_COEFF_SET (0xE).
  function automatic logic [3:0] coef_addr(input logic [2:0] idx);
    return ADDR_F0 + {idx, 1'b0};
  endfunction

endpackage

// File: rtl/ahb_fir_sample_master_if.sv
// rtl/ahb_fir_sample_master_if.sv - AHB-Lite signal bundle between the FIR master and its slave
interface ahb_fir_sample_master_if;

  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hsize;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hresp
  );

endinterface

// File: rtl/ahb_fir_sample_master.sv
// rtl/ahb_fir_sample_master.sv - AHB-Lite master: writes samples/coefficients to the FIR, polls, returns results
module ahb_fir_sample_master
  import fir_master_pkg::*;
#(
  parameter int POLL_LIMIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_sample_valid,
  input  logic [15:0]             i_sample_in,
  output logic                    o_sample_ready,
  input  logic                    i_coeff_start,
  input  logic [63:0]             i_coeff_in,
  output logic                    o_result_valid,
  output logic [15:0]             o_result_out,
  input  logic                    i_result_ready,
  output logic                    o_busy,
  output logic                    o_bus_err,
  input  logic                    i_clear_err,
  output logic [15:0]             o_sample_count,
  ahb_fir_sample_master_if.master ahb
);

  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  state_t          r_state;
  state_t          w_next;
  op_t             r_op;
  logic [15:0]     r_sample;
  logic [63:0]     r_coeff;
  logic [2:0]      r_cf_idx;
  logic [PCW-1:0]  r_poll_cnt;
  logic            r_result_valid;
  logic [15:0]     r_result;
  logic            r_bus_err;
  logic [15:0]     r_sample_count;

  logic            w_acc_sample;
  logic            w_acc_coeff;
  logic            w_err_set;
  logic            w_poll_clr;
  logic            w_poll_inc;
  logic            w_cf_inc;
  logic            w_capture;
  logic            w_deliver;
  logic            w_poll_done;
  logic            w_status_err;

  logic [1:0]      w_htrans;
  logic [3:0]      w_haddr;
  logic            w_hwrite;
  logic [15:0]     w_hwdata;
  logic [3:0]      w_poll_addr;
  logic [15:0]     w_cf_data;

  // Both the STATUS busy flag and the NEW_COEFF_SET flag live in bit 0.
  assign w_poll_done  = ~ahb.hrdata[STATUS_BUSY_BIT];
  assign w_status_err = (r_op == OP_SAMPLE) && ahb.hrdata[STATUS_ERR_BIT];
  assign w_poll_addr  = (r_op == OP_COEFF) ? ADDR_NEWCOEF : ADDR_STATUS;

  always_comb begin
    w_next       = r_state;
    w_acc_sample = 1'b0;
    w_acc_coeff  = 1'b0;
    w_err_set    = 1'b0;
    w_poll_clr   = 1'b0;
    w_poll_inc   = 1'b0;
    w_cf_inc     = 1'b0;
    w_capture    = 1'b0;
    w_deliver    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_coeff_start) begin
          w_acc_coeff = 1'b1;
          w_next      = ST_CF_A;
        end else if (i_sample_valid && !r_result_valid) begin
          w_acc_sample = 1'b1;
          w_next       = ST_SMP_A;
        end
      end
      ST_SMP_A: w_next = ST_SMP_D;
      ST_SMP_D: begin
        if (ahb.hresp) begin
          w_err_set = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_poll_clr = 1'b1;
          w_next     = ST_POLL_A;
        end
      end
      ST_CF_A: w_next = ST_CF_D;
      ST_CF_D: begin
        if (ahb.hresp) begin
          w_err_set = 1'b1;
          w_next    = ST_IDLE;
        end else if (r_cf_idx == CF_LAST_IDX) begin
          w_poll_clr = 1'b1;
          w_next     = ST_POLL_A;
        end else begin
          w_cf_inc = 1'b1;
          w_next   = ST_CF_A;
        end
      end
      ST_POLL_A: w_next = ST_POLL_D;
      ST_POLL_D: begin
        if (ahb.hresp || w_status_err) begin
          w_err_set = 1'b1;
          w_next    = ST_IDLE;
        end else if (w_poll_done) begin
          w_next = (r_op == OP_SAMPLE) ? ST_RES_A : ST_IDLE;
        end else if (r_poll_cnt == POLL_LAST) begin
          w_err_set = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_poll_inc = 1'b1;
          w_next     = ST_POLL_A;
        end
      end
      ST_RES_A: w_next = ST_RES_D;
      ST_RES_D: begin
        if (ahb.hresp) begin
          w_err_set = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (i_result_ready) begin
          w_deliver = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cf_data = 16'h0001;
    case (r_cf_idx)
      3'd0:    w_cf_data = r_coeff[15:0];
      3'd1:    w_cf_data = r_coeff[31:16];
      3'd2:    w_cf_data = r_coeff[47:32];
      3'd3:    w_cf_data = r_coeff[63:48];
      default: w_cf_data = 16'h0001;
    endcase
  end

  // Address/control are held through the data phase; only htrans marks the address phase.
  always_comb begin
    w_htrans = HTRANS_IDLE;
    w_haddr  = 4'h0;
    w_hwrite = 1'b0;
    w_hwdata = 16'h0000;
    case (r_state)
      ST_SMP_A: begin
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = ADDR_SAMPLE;
        w_hwrite = 1'b1;
      end
      ST_SMP_D: begin
        w_haddr  = ADDR_SAMPLE;
        w_hwrite = 1'b1;
        w_hwdata = r_sample;
      end
      ST_CF_A: begin
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = coef_addr(r_cf_idx);
        w_hwrite = 1'b1;
      end
      ST_CF_D: begin
        w_haddr  = coef_addr(r_cf_idx);
        w_hwrite = 1'b1;
        w_hwdata = w_cf_data;
      end
      ST_POLL_A: begin
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = w_poll_addr;
      end
      ST_POLL_D: w_haddr = w_poll_addr;
      ST_RES_A: begin
        w_htrans = HTRANS_NONSEQ;
        w_haddr  = ADDR_RESULT;
      end
      ST_RES_D: w_haddr = ADDR_RESULT;
      default: ;
    endcase
  end

  assign ahb.htrans = w_htrans;
  assign ahb.hsel   = (w_htrans == HTRANS_NONSEQ);
  assign ahb.haddr  = w_haddr;
  assign ahb.hwrite = w_hwrite;
  assign ahb.hsize  = 1'b1;
  assign ahb.hwdata = w_hwdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_SAMPLE;
      r_sample       <= 16'h0000;
      r_coeff        <= 64'h0;
      r_cf_idx       <= 3'd0;
      r_poll_cnt     <= '0;
      r_result_valid <= 1'b0;
      r_result       <= 16'h0000;
      r_bus_err      <= 1'b0;
      r_sample_count <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_acc_sample) begin
        r_sample <= i_sample_in;
        r_op     <= OP_SAMPLE;
      end
      if (w_acc_coeff) begin
        r_coeff  <= i_coeff_in;
        r_op     <= OP_COEFF;
        r_cf_idx <= 3'd0;
      end else if (w_cf_inc) begin
        r_cf_idx <= r_cf_idx + 3'd1;
      end
      if (w_poll_clr) begin
        r_poll_cnt <= '0;
      end else if (w_poll_inc) begin
        r_poll_cnt <= r_poll_cnt + PCW'(1);
      end
      if (w_capture) begin
        r_result       <= ahb.hrdata;
        r_result_valid <= 1'b1;
      end else if (w_deliver) begin
        r_result_valid <= 1'b0;
        r_sample_count <= r_sample_count + 16'd1;
      end
      // Software clear takes priority over an error raised in the same cycle.
      if (i_clear_err) begin
        r_bus_err <= 1'b0;
      end else if (w_err_set) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign o_sample_ready = (r_state == ST_IDLE) && !r_result_valid && !i_coeff_start;
  assign o_result_valid = r_result_valid;
  assign o_result_out   = r_result;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_bus_err      = r_bus_err;
  assign o_sample_count = r_sample_count;

endmodule

// File: tb/tb_ahb_fir_sample_master.sv
// tb/tb_ahb_fir_sample_master.sv - bench for ahb_fir_sample_master with a scripted FIR slave and op-log reference
module tb_ahb_fir_sample_master;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
  } op_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sample_valid = 1'b0;
  logic [15:0] i_sample_in = 16'h0;
  logic        o_sample_ready;
  logic        i_coeff_start = 1'b0;
  logic [63:0] i_coeff_in = 64'h0;
  logic        o_result_valid;
  logic [15:0] o_result_out;
  logic        i_result_ready = 1'b0;
  logic        o_busy;
  logic        o_bus_err;
  logic        i_clear_err = 1'b0;
  logic [15:0] o_sample_count;

  ahb_fir_sample_master_if ahb ();

  ahb_fir_sample_master #(.POLL_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample_valid (i_sample_valid),
    .i_sample_in    (i_sample_in),
    .o_sample_ready (o_sample_ready),
    .i_coeff_start  (i_coeff_start),
    .i_coeff_in     (i_coeff_in),
    .o_result_valid (o_result_valid),
    .o_result_out   (o_result_out),
    .i_result_ready (i_result_ready),
    .o_busy         (o_busy),
    .o_bus_err      (o_bus_err),
    .i_clear_err    (i_clear_err),
    .o_sample_count (o_sample_count),
    .ahb            (ahb)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          st_busy_left = 0;
  int          nc_busy_left = 0;
  bit          st_err = 1'b0;
  bit          inj_arm = 1'b0;
  logic [3:0]  inj_addr = 4'h0;
  logic [15:0] res_val = 16'h0;
  logic [15:0] model_count = 16'h0;
  op_rec_t     log_q[$];
  op_rec_t     exp_q[$];

  bit          ph_pend = 1'b0;
  logic [3:0]  ph_addr = 4'h0;
  logic        ph_wr = 1'b0;
  logic [15:0] mon_rd;
  op_rec_t     mon_rec;

  // Peripheral model: answers the data phase of each address phase seen on the previous negedge.
  always @(negedge clk) begin
    if (rst) begin
      ph_pend = 1'b0;
      ahb.hrdata = 16'h0;
      ahb.hresp = 1'b0;
    end else begin
      if (ph_pend) begin
        mon_rd = 16'h0;
        if (!ph_wr) begin
          case (ph_addr)
            4'h0: begin
              if (st_busy_left > 0) begin
                st_busy_left--;
                mon_rd = 16'h0001;
              end else begin
                mon_rd = st_err ? 16'h0100 : 16'h0000;
              end
            end
            4'h2: mon_rd = res_val;
            4'hE: begin
              if (nc_busy_left > 0) begin
                nc_busy_left--;
                mon_rd = 16'h0001;
              end else begin
                mon_rd = 16'h0000;
              end
            end
            default: mon_rd = 16'hDEAD;
          endcase
        end
        ahb.hrdata = mon_rd;
        ahb.hresp = inj_arm && (inj_addr == ph_addr);
        if (ahb.hresp) inj_arm = 1'b0;
        mon_rec.wr = ph_wr;
        mon_rec.addr = ph_addr;
        mon_rec.data = ph_wr ? ahb.hwdata : mon_rd;
        log_q.push_back(mon_rec);
        ph_pend = 1'b0;
      end else begin
        ahb.hrdata = 16'h0;
        ahb.hresp = 1'b0;
      end
      checks++;
      if (ahb.hsel !== (ahb.htrans == 2'b10) || ahb.hsize !== 1'b1 ||
          (ahb.htrans !== 2'b00 && ahb.htrans !== 2'b10)) begin
        failures++;
        $display("FAIL bus_protocol: hsel=%b htrans=%b hsize=%b want hsel==(htrans==10), htrans in {00,10}, hsize=1",
                 ahb.hsel, ahb.htrans, ahb.hsize);
      end
      if (ahb.htrans == 2'b10) begin
        ph_pend = 1'b1;
        ph_addr = ahb.haddr;
        ph_wr = ahb.hwrite;
      end
    end
  end

  function automatic int log_diff();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (log_q[i] !== exp_q[i]) return i;
    end
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic slave_cfg(input int k_st, input bit err, input int k_nc, input logic [15:0] r);
    st_busy_left = k_st;
    st_err = err;
    nc_busy_left = k_nc;
    res_val = r;
  endtask

  task automatic exp_w(input logic [3:0] a, input logic [15:0] d);
    op_rec_t e;
    e.wr = 1'b1;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_r(input logic [3:0] a, input logic [15:0] d);
    op_rec_t e;
    e.wr = 1'b0;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Sample op: write SAMPLE, k busy STATUS reads, one idle STATUS read, one RESULT read.
  task automatic exp_sample_ok(input logic [15:0] s, input int k, input logic [15:0] r);
    exp_w(4'h4, s);
    repeat (k) exp_r(4'h0, 16'h0001);
    exp_r(4'h0, 16'h0000);
    exp_r(4'h2, r);
  endtask

  task automatic exp_coeff_writes(input logic [63:0] c, input int upto);
    for (int j = 0; j <= upto; j++) begin
      if (j < 4) exp_w(4'(6 + 2 * j), c[16*j +: 16]);
      else exp_w(4'hE, 16'h0001);
    end
  endtask

  task automatic start_sample(input logic [15:0] s);
    int n;
    n = 0;
    i_sample_valid = 1'b1;
    i_sample_in = s;
    while (!o_sample_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL sample_ready_timeout: ready=%b after %0d cycles, want 1", o_sample_ready, n);
    end
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic start_coeff(input logic [63:0] c);
    i_coeff_start = 1'b1;
    i_coeff_in = c;
    tick();
    i_coeff_start = 1'b0;
  endtask

  task automatic wait_end(output int n);
    tick();
    n = 1;
    while (o_busy && !o_result_valid && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL op_timeout: busy=%b result_valid=%b after %0d cycles, want completion", o_busy, o_result_valid, n);
    end
  endtask

  task automatic consume();
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    model_count++;
  endtask

  task automatic pulse_clear();
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ahb.htrans !== 2'b00 || ahb.hsel !== 1'b0 || ahb.hwrite !== 1'b0 || ahb.haddr !== 4'h0 ||
        ahb.hwdata !== 16'h0 || ahb.hsize !== 1'b1) begin
      failures++;
      $display("FAIL reset_bus: htrans=%b hsel=%b hwrite=%b haddr=%h hwdata=%h hsize=%b want all 0, hsize=1",
               ahb.htrans, ahb.hsel, ahb.hwrite, ahb.haddr, ahb.hwdata, ahb.hsize);
    end
    checks++;
    if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_bus_err !== 1'b0 ||
        o_sample_count !== 16'h0 || o_result_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b rv=%b err=%b cnt=%h res=%h want all 0",
               o_busy, o_result_valid, o_bus_err, o_sample_count, o_result_out);
    end
    checks++;
    if (o_sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: sample_ready=%b want 1", o_sample_ready);
    end
  endtask

  task automatic test_sample();
    int n, k, d;
    logic [15:0] s, r;
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        s = 16'h0100; k = 2; r = 16'h1234;
      end else begin
        s = 16'($urandom); k = $urandom_range(0, LIMIT - 1); r = 16'($urandom);
      end
      new_op();
      slave_cfg(k, 1'b0, 0, r);
      exp_sample_ok(s, k, r);
      start_sample(s);
      wait_end(n);
      checks++;
      if (o_result_valid !== 1'b1 || o_result_out !== r) begin
        failures++;
        $display("FAIL sample_result[%0d]: rv=%b result=%h want rv=1 result=%h", it, o_result_valid, o_result_out, r);
      end
      checks++;
      if (n != 6 + 2 * k) begin
        failures++;
        $display("FAIL sample_latency[%0d]: %0d cycles want %0d", it, n, 6 + 2 * k);
      end
      d = log_diff();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL sample_bus_log[%0d]: first difference at op %0d, got %0d ops want %0d", it, d, log_q.size(), exp_q.size());
      end
      repeat ($urandom_range(0, 3)) tick();
      consume();
      checks++;
      if (o_sample_count !== model_count || o_result_valid !== 1'b0) begin
        failures++;
        $display("FAIL sample_count[%0d]: cnt=%h rv=%b want cnt=%h rv=0", it, o_sample_count, o_result_valid, model_count);
      end
    end
  endtask

  task automatic test_coeff();
    int n, k, d;
    logic [63:0] c;
    for (int it = 0; it < 4; it++) begin
      c = (it == 0) ? 64'h1000_2000_4000_8000 : {$urandom, $urandom};
      k = $urandom_range(0, LIMIT - 1);
      new_op();
      slave_cfg(0, 1'b0, k, 16'h0);
      exp_coeff_writes(c, 4);
      repeat (k) exp_r(4'hE, 16'h0001);
      exp_r(4'hE, 16'h0000);
      i_sample_valid = 1'b1;
      i_sample_in = 16'($urandom);
      i_coeff_start = 1'b1;
      i_coeff_in = c;
      #1;
      checks++;
      if (o_sample_ready !== 1'b0) begin
        failures++;
        $display("FAIL coeff_priority[%0d]: sample_ready=%b want 0 with coeff_start", it, o_sample_ready);
      end
      tick();
      i_coeff_start = 1'b0;
      i_sample_valid = 1'b0;
      wait_end(n);
      checks++;
      if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_sample_count !== model_count) begin
        failures++;
        $display("FAIL coeff_end[%0d]: busy=%b rv=%b cnt=%h want 0 0 %h", it, o_busy, o_result_valid, o_sample_count, model_count);
      end
      checks++;
      if (n != 12 + 2 * k) begin
        failures++;
        $display("FAIL coeff_latency[%0d]: %0d cycles want %0d", it, n, 12 + 2 * k);
      end
      d = log_diff();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL coeff_bus_log[%0d]: first difference at op %0d, got %0d ops want %0d", it, d, log_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_status_err();
    int n, k, d;
    logic [15:0] s;
    k = $urandom_range(0, 2);
    s = 16'($urandom);
    new_op();
    slave_cfg(k, 1'b1, 0, 16'h0);
    exp_w(4'h4, s);
    repeat (k) exp_r(4'h0, 16'h0001);
    exp_r(4'h0, 16'h0100);
    start_sample(s);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL status_err_log: first difference at op %0d, got %0d ops want %0d", d, log_q.size(), exp_q.size());
    end
    checks++;
    if (o_bus_err !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0 || n != 4 + 2 * k) begin
      failures++;
      $display("FAIL status_err_state: err=%b busy=%b rv=%b cycles=%0d want 1 0 0 %0d", o_bus_err, o_busy, o_result_valid, n, 4 + 2 * k);
    end
    pulse_clear();
    checks++;
    if (o_bus_err !== 1'b0) begin
      failures++;
      $display("FAIL clear_err: bus_err=%b want 0", o_bus_err);
    end
    slave_cfg(0, 1'b1, 0, 16'h0);
    start_sample(16'($urandom));
    wait_end(n);
    checks++;
    if (o_bus_err !== 1'b1) begin
      failures++;
      $display("FAIL status_err_again: bus_err=%b want 1", o_bus_err);
    end
    slave_cfg(0, 1'b1, 0, 16'h0);
    start_sample(16'($urandom));
    repeat (3) tick();
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    checks++;
    if (o_bus_err !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_beats_set: bus_err=%b busy=%b want 0 0", o_bus_err, o_busy);
    end
    slave_cfg(0, 1'b1, 0, 16'h0);
    start_sample(16'($urandom));
    wait_end(n);
    checks++;
    if (o_bus_err !== 1'b1 || o_sample_count !== model_count) begin
      failures++;
      $display("FAIL status_err_final: bus_err=%b cnt=%h want 1 %h", o_bus_err, o_sample_count, model_count);
    end
    slave_cfg(0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_reset_mid_poll();
    slave_cfg(20, 1'b0, 0, 16'h0);
    new_op();
    start_sample(16'($urandom));
    repeat ($urandom_range(2, 7)) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ahb.htrans !== 2'b00 || o_busy !== 1'b0 || o_result_valid !== 1'b0 ||
        o_bus_err !== 1'b0 || o_sample_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_poll: htrans=%b busy=%b rv=%b err=%b cnt=%h want all 0",
               ahb.htrans, o_busy, o_result_valid, o_bus_err, o_sample_count);
    end
    rst = 1'b0;
    model_count = 16'h0;
    slave_cfg(0, 1'b0, 0, 16'h0);
    tick();
    checks++;
    if (o_sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_poll_ready: sample_ready=%b want 1", o_sample_ready);
    end
  endtask

  task automatic test_hresp();
    int n, k, d, j;
    logic [15:0] s, r;
    logic [63:0] c;
    s = 16'($urandom);
    new_op();
    slave_cfg(0, 1'b0, 0, 16'h0);
    inj_arm = 1'b1;
    inj_addr = 4'h4;
    exp_w(4'h4, s);
    start_sample(s);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1 || o_bus_err !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0 || n != 2) begin
      failures++;
      $display("FAIL hresp_sample: logdiff=%0d err=%b busy=%b rv=%b cycles=%0d want -1 1 0 0 2",
               d, o_bus_err, o_busy, o_result_valid, n);
    end
    s = 16'($urandom); k = $urandom_range(0, LIMIT - 1); r = 16'($urandom);
    new_op();
    slave_cfg(k, 1'b0, 0, r);
    exp_sample_ok(s, k, r);
    start_sample(s);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1 || o_result_valid !== 1'b1 || o_result_out !== r || o_bus_err !== 1'b1) begin
      failures++;
      $display("FAIL after_hresp_sample: logdiff=%0d rv=%b result=%h err=%b want -1 1 %h 1",
               d, o_result_valid, o_result_out, o_bus_err, r);
    end
    consume();
    checks++;
    if (o_sample_count !== model_count) begin
      failures++;
      $display("FAIL after_hresp_count: cnt=%h want %h", o_sample_count, model_count);
    end
    pulse_clear();
    j = $urandom_range(0, 4);
    c = {$urandom, $urandom};
    new_op();
    inj_arm = 1'b1;
    inj_addr = 4'(6 + 2 * j);
    exp_coeff_writes(c, j);
    start_coeff(c);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1 || o_bus_err !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL hresp_coeff[idx %0d]: logdiff=%0d err=%b busy=%b want -1 1 0", j, d, o_bus_err, o_busy);
    end
    inj_arm = 1'b0;
    pulse_clear();
  endtask

  task automatic test_poll_timeout();
    int n, d;
    logic [15:0] s, r;
    s = 16'($urandom);
    new_op();
    slave_cfg(LIMIT + $urandom_range(0, 5), 1'b0, 0, 16'h0);
    exp_w(4'h4, s);
    repeat (LIMIT) exp_r(4'h0, 16'h0001);
    start_sample(s);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL timeout_log: first difference at op %0d, got %0d ops want %0d", d, log_q.size(), exp_q.size());
    end
    checks++;
    if (o_bus_err !== 1'b1 || o_busy !== 1'b0 || o_result_valid !== 1'b0 || n != 2 + 2 * LIMIT) begin
      failures++;
      $display("FAIL timeout_state: err=%b busy=%b rv=%b cycles=%0d want 1 0 0 %0d",
               o_bus_err, o_busy, o_result_valid, n, 2 + 2 * LIMIT);
    end
    pulse_clear();
    s = 16'($urandom); r = 16'($urandom);
    new_op();
    slave_cfg(LIMIT - 1, 1'b0, 0, r);
    exp_sample_ok(s, LIMIT - 1, r);
    start_sample(s);
    wait_end(n);
    d = log_diff();
    checks++;
    if (d != -1 || o_result_valid !== 1'b1 || o_result_out !== r || o_bus_err !== 1'b0) begin
      failures++;
      $display("FAIL last_poll_ok: logdiff=%0d rv=%b result=%h err=%b want -1 1 %h 0",
               d, o_result_valid, o_result_out, o_bus_err, r);
    end
    consume();
  endtask

  task automatic test_result_hold();
    int n, d;
    logic [15:0] s, r;
    s = 16'($urandom); r = 16'($urandom);
    new_op();
    slave_cfg(0, 1'b0, 0, r);
    exp_sample_ok(s, 0, r);
    start_sample(s);
    wait_end(n);
    i_sample_valid = 1'b1;
    i_sample_in = 16'($urandom);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (o_sample_ready !== 1'b0 || ahb.htrans !== 2'b00 || o_result_valid !== 1'b1 || o_result_out !== r) begin
        failures++;
        $display("FAIL result_hold[%0d]: ready=%b htrans=%b rv=%b result=%h want 0 00 1 %h",
                 c, o_sample_ready, ahb.htrans, o_result_valid, o_result_out, r);
      end
      tick();
    end
    i_sample_valid = 1'b0;
    d = log_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL result_hold_log: first difference at op %0d, got %0d ops want %0d", d, log_q.size(), exp_q.size());
    end
    consume();
    checks++;
    if (o_sample_count !== model_count || o_result_valid !== 1'b0) begin
      failures++;
      $display("FAIL result_hold_count: cnt=%h rv=%b want %h 0", o_sample_count, o_result_valid, model_count);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_sample();
    test_coeff();
    test_status_err();
    test_reset_mid_poll();
    test_hresp();
    test_poll_timeout();
    test_result_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
